// File: rtl/micro_sequencer_if.sv
// Command, memory and writeback signals of micro_sequencer.
// slave: the sequencer side; master: the decoder/memory/datapath side.
interface micro_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] micro_cmd;
  logic        hit;
  logic        br_taken;
  logic [2:0]  alu_op;
  logic        alu_unsign;
  logic [2:0]  imm_type;
  logic        alu_src_pc;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic        mem_err;
  logic        reg_wen;
  logic        wb_sel_mem;
  logic        pc_wen;
  logic        pc_sel_jump;
  logic        retire;
  logic        illegal;
  logic        busy;

  modport slave (
    input  in_valid, micro_cmd, hit, br_taken, mem_ack,
    output in_ready, alu_op, alu_unsign, imm_type, alu_src_pc,
           mem_req, mem_we, mem_size, mem_err,
           reg_wen, wb_sel_mem, pc_wen, pc_sel_jump, retire, illegal, busy
  );

  modport master (
    output in_valid, micro_cmd, hit, br_taken, mem_ack,
    input  in_ready, alu_op, alu_unsign, imm_type, alu_src_pc,
           mem_req, mem_we, mem_size, mem_err,
           reg_wen, wb_sel_mem, pc_wen, pc_sel_jump, retire, illegal, busy
  );
endinterface

// File: rtl/micro_sequencer.sv
// Moore IDLE/EXEC/MEM/WB sequencer for one decoded micro-command at a time.
// Optional MEM timeout (16 cycles without mem_ack) under `MICRO_SEQ_TIMEOUT_EN.
module micro_sequencer (
  input  logic               clk,
  input  logic               rst,
  micro_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t      state_q, state_d;
  logic [13:0] cmd_q, cmd_d;
  logic        jump_q, jump_d;
  logic        illegal_q, illegal_d;

  logic       regen, pcjen, pcren, unsign;
  logic [1:0] mwen, mren;
  logic [2:0] aluop, immt;

  assign regen  = cmd_q[13];
  assign pcjen  = cmd_q[12];
  assign pcren  = cmd_q[11];
  assign mwen   = cmd_q[10:9];
  assign mren   = cmd_q[8:7];
  assign aluop  = cmd_q[6:4];
  assign unsign = cmd_q[3];
  assign immt   = cmd_q[2:0];

`ifdef MICRO_SEQ_TIMEOUT_EN
  logic [4:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    jump_d    = jump_q;
    illegal_d = 1'b0;
`ifdef MICRO_SEQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.hit) begin
            cmd_d   = bus.micro_cmd;
            jump_d  = 1'b0;
            state_d = EXEC;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        // Conditional branches use imm_type 3'b011; every other PCJEN form always jumps.
        if (pcjen) jump_d = (immt == 3'b011) ? bus.br_taken : 1'b1;
        else       jump_d = 1'b0;
        if ((mwen != 2'b00) && (mren != 2'b00)) begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end else if ((mwen != 2'b00) || (mren != 2'b00)) begin
          state_d = MEM;
`ifdef MICRO_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          state_d = WB;
`ifdef MICRO_SEQ_TIMEOUT_EN
        end else if (cnt_q == 5'd15) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
`endif
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MICRO_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      jump_q    <= jump_d;
      illegal_q <= illegal_d;
`ifdef MICRO_SEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  logic active, in_mem, in_wb;
  assign active = (state_q != IDLE);
  assign in_mem = (state_q == MEM);
  assign in_wb  = (state_q == WB);

  assign bus.in_ready    = !active;
  assign bus.busy        = active;
  assign bus.alu_op      = active ? aluop : '0;
  assign bus.alu_unsign  = active & unsign;
  assign bus.imm_type    = active ? immt : '0;
  assign bus.alu_src_pc  = active & pcren;
  assign bus.mem_req     = in_mem;
  assign bus.mem_we      = in_mem & (mwen != 2'b00);
  assign bus.mem_size    = !in_mem ? 2'b00 : ((mwen != 2'b00) ? mwen : mren);
  assign bus.reg_wen     = in_wb & regen;
  assign bus.wb_sel_mem  = in_wb & (mren != 2'b00);
  assign bus.pc_wen      = in_wb;
  assign bus.pc_sel_jump = in_wb & jump_q;
  assign bus.retire      = in_wb;
  assign bus.illegal     = illegal_q;
`ifdef MICRO_SEQ_TIMEOUT_EN
  assign bus.mem_err     = err_q;
`else
  assign bus.mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: retire/illegal/mem_err events are
// predicted into a queue and popped by a monitor when the DUT reports them.
module tb_micro_sequencer;

  logic clk;
  logic rst;
  micro_sequencer_if bus_if ();

  micro_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] sb[$];

  logic [19:0] outs_v;
  logic [6:0]  ev_v;
  assign outs_v = {bus_if.alu_op, bus_if.alu_unsign, bus_if.imm_type, bus_if.alu_src_pc,
                   bus_if.mem_req, bus_if.mem_we, bus_if.mem_size, bus_if.mem_err,
                   bus_if.reg_wen, bus_if.wb_sel_mem, bus_if.pc_wen, bus_if.pc_sel_jump,
                   bus_if.retire, bus_if.illegal, bus_if.busy};
  // {retire, illegal, mem_err, reg_wen, wb_sel_mem, pc_sel_jump, pc_wen}
  assign ev_v = {bus_if.retire, bus_if.illegal, bus_if.mem_err, bus_if.reg_wen,
                 bus_if.wb_sel_mem, bus_if.pc_sel_jump, bus_if.pc_wen};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] mk_ret(input logic regen, input logic wbm, input logic jmp);
    return {1'b1, 2'b00, regen, wbm, jmp, 1'b1};
  endfunction

  localparam logic [6:0] EV_ILLEGAL = 7'b0100000;
  localparam logic [6:0] EV_MEMERR  = 7'b0010000;

  always @(negedge clk) begin
    if (!rst && (bus_if.retire || bus_if.illegal || bus_if.mem_err)) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'(ev_v), 32'(0));
      else                chk("sb_event", 32'(ev_v), 32'(sb.pop_front()));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [13:0] cmd, input logic h, input logic br);
    bus_if.in_valid  = 1'b1;
    bus_if.micro_cmd = cmd;
    bus_if.hit       = h;
    bus_if.br_taken  = br;
    cyc();
    bus_if.in_valid  = 1'b0;
    bus_if.hit       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.micro_cmd = '0;
    bus_if.hit       = 1'b0;
    bus_if.br_taken  = 1'b0;
    bus_if.mem_ack   = 1'b0;
    #1;
    chk("reset_ready", 32'(bus_if.in_ready), 32'(1));
    chk("reset_outs", 32'(outs_v), 32'(0));
    cyc();
    cyc();
    rst = 1'b0;

    // ADDI
    sb.push_back(mk_ret(1'b1, 1'b0, 1'b0));
    send(14'h2001, 1'b1, 1'b0);
    chk("addi_exec_busy", 32'({bus_if.in_ready, bus_if.busy}), 32'(2'b01));
    chk("addi_exec_fields", 32'({bus_if.alu_op, bus_if.alu_unsign, bus_if.imm_type, bus_if.alu_src_pc}),
        32'({3'd0, 1'b0, 3'd1, 1'b0}));
    cyc();
    chk("addi_wb", 32'({bus_if.retire, bus_if.reg_wen, bus_if.pc_wen, bus_if.pc_sel_jump}), 32'(4'b1110));
    cyc();
    chk("addi_ready", 32'(bus_if.in_ready), 32'(1));
    chk("idle_fields_zero", 32'(outs_v), 32'(0));

    // BEQ taken / not taken, JAL
    sb.push_back(mk_ret(1'b0, 1'b0, 1'b1));
    send(14'h1803, 1'b1, 1'b1);
    chk("beq_exec_fields", 32'({bus_if.alu_src_pc, bus_if.imm_type}), 32'(4'b1011));
    cyc();
    chk("beq_t_wb", 32'({bus_if.pc_sel_jump, bus_if.reg_wen}), 32'(2'b10));
    cyc();
    sb.push_back(mk_ret(1'b0, 1'b0, 1'b0));
    send(14'h1803, 1'b1, 1'b0);
    cyc();
    chk("beq_nt_wb", 32'({bus_if.retire, bus_if.pc_sel_jump}), 32'(2'b10));
    cyc();
    sb.push_back(mk_ret(1'b1, 1'b0, 1'b1));
    send(14'h3807, 1'b1, 1'b0);
    cyc();
    chk("jal_wb", 32'({bus_if.pc_sel_jump, bus_if.reg_wen}), 32'(2'b11));
    cyc();

    // all-zero command
    sb.push_back(mk_ret(1'b0, 1'b0, 1'b0));
    send(14'h0000, 1'b1, 1'b0);
    cyc();
    chk("zero_wb", 32'({bus_if.retire, bus_if.reg_wen, bus_if.pc_wen, bus_if.pc_sel_jump}), 32'(4'b1010));
    cyc();

    // decoder miss
    sb.push_back(EV_ILLEGAL);
    send(14'h2001, 1'b0, 1'b0);
    chk("nohit_illegal", 32'({bus_if.illegal, bus_if.in_ready}), 32'(2'b11));
    cyc();
    chk("nohit_one_pulse", 32'({bus_if.illegal, bus_if.in_ready}), 32'(2'b01));

    // both MWEN and MREN
    sb.push_back(EV_ILLEGAL);
    send(14'h0781, 1'b1, 1'b0);
    chk("both_exec_nomem", 32'(bus_if.mem_req), 32'(0));
    cyc();
    chk("both_illegal", 32'({bus_if.illegal, bus_if.in_ready, bus_if.mem_req, bus_if.retire}), 32'(4'b1100));
    cyc();
    chk("both_one_pulse", 32'(bus_if.illegal), 32'(0));

    // LW, ack in third MEM cycle
    sb.push_back(mk_ret(1'b1, 1'b1, 1'b0));
    send(14'h2181, 1'b1, 1'b0);
    chk("lw_exec_nomem", 32'(bus_if.mem_req), 32'(0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lw_mem", 32'({bus_if.mem_req, bus_if.mem_we, bus_if.mem_size}), 32'(4'b1011));
    end
    bus_if.mem_ack = 1'b1;
    cyc();
    bus_if.mem_ack = 1'b0;
    chk("lw_wb", 32'({bus_if.retire, bus_if.reg_wen, bus_if.wb_sel_mem, bus_if.mem_req}), 32'(4'b1110));
    cyc();

    // SB: ack held through IDLE/EXEC must be ignored
    sb.push_back(mk_ret(1'b0, 1'b0, 1'b0));
    bus_if.mem_ack = 1'b1;
    send(14'h0200, 1'b1, 1'b0);
    bus_if.mem_ack = 1'b0;
    cyc();
    chk("sb_mem", 32'({bus_if.mem_req, bus_if.mem_we, bus_if.mem_size}), 32'(4'b1101));
    cyc();
    chk("sb_early_ack_ignored", 32'(bus_if.mem_req), 32'(1));
    bus_if.mem_ack = 1'b1;
    cyc();
    bus_if.mem_ack = 1'b0;
    chk("sb_wb", 32'({bus_if.retire, bus_if.wb_sel_mem, bus_if.reg_wen}), 32'(3'b100));
    cyc();

    // SH: ack in first MEM cycle
    sb.push_back(mk_ret(1'b0, 1'b0, 1'b0));
    send(14'h0400, 1'b1, 1'b0);
    cyc();
    chk("sh_mem", 32'({bus_if.mem_req, bus_if.mem_we, bus_if.mem_size}), 32'(4'b1110));
    bus_if.mem_ack = 1'b1;
    cyc();
    bus_if.mem_ack = 1'b0;
    chk("sh_min_one_mem", 32'({bus_if.retire, bus_if.mem_req}), 32'(2'b10));
    cyc();

    // SW with no ack
`ifdef MICRO_SEQ_TIMEOUT_EN
    sb.push_back(EV_MEMERR);
`endif
    send(14'h0602, 1'b1, 1'b0);
    repeat (16) cyc();
    chk("sw_mem16", 32'({bus_if.mem_req, bus_if.mem_we, bus_if.mem_size}), 32'(4'b1111));
    cyc();
`ifdef MICRO_SEQ_TIMEOUT_EN
    chk("sw_timeout", 32'({bus_if.mem_err, bus_if.mem_req, bus_if.in_ready, bus_if.retire}), 32'(4'b1010));
    cyc();
    chk("sw_err_one_pulse", 32'(bus_if.mem_err), 32'(0));
    send(14'h0602, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("sw2_in_mem", 32'(bus_if.mem_req), 32'(1));
`else
    chk("sw_waits", 32'({bus_if.mem_err, bus_if.mem_req}), 32'(2'b01));
    repeat (4) cyc();
    chk("sw_still_waits", 32'(bus_if.mem_req), 32'(1));
`endif

    // asynchronous reset mid-MEM, away from any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem", 32'({bus_if.mem_req, bus_if.retire, bus_if.in_ready, bus_if.busy}), 32'(4'b0010));
    chk("rst_mid_mem_outs", 32'(outs_v), 32'(0));
    cyc();
    rst = 1'b0;

    // recovery after reset
    sb.push_back(mk_ret(1'b1, 1'b0, 1'b0));
    send(14'h2001, 1'b1, 1'b0);
    cyc();
    chk("post_rst_retire", 32'({bus_if.retire, bus_if.reg_wen}), 32'(2'b11));
    cyc();
    cyc();

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_valid in 1 (decoded command offered); in_ready out 1 (sequencer can accept).
REQ-004 SHALL have ports: micro_cmd in 14 ([13]REGEN [12]PCJEN [11]PCREN [10:9]MWEN [8:7]MREN [6:4]ALUOP [3]UNSIGN [2:0]IMM_TYPE); hit in 1 (decoder matched a pattern).
REQ-005 SHALL have ports: br_taken in 1 (branch compare result from ALU, sampled in EXEC).
REQ-006 SHALL have ports: alu_op out 3, alu_unsign out 1, imm_type out 3, alu_src_pc out 1 (latched PCREN).
REQ-007 SHALL have ports: mem_req out 1, mem_we out 1, mem_size out 2 (01 byte, 10 half, 11 word), mem_ack in 1, mem_err out 1.
REQ-008 SHALL have ports: reg_wen out 1, wb_sel_mem out 1, pc_wen out 1, pc_sel_jump out 1, retire out 1, illegal out 1, busy out 1.

Function
REQ-009 SHALL implement a Moore FSM with states IDLE, EXEC, MEM, WB; all outputs SHALL be decoded from registered state and the latched command only.
REQ-010 SHALL assert in_ready only in IDLE; busy = !in_ready.
REQ-011 IDLE: in_valid&hit SHALL latch micro_cmd and go to EXEC; in_valid&!hit SHALL stay IDLE and pulse illegal for exactly one cycle on the following cycle.
REQ-012 alu_op/alu_unsign/imm_type/alu_src_pc SHALL hold the latched fields from EXEC through WB, and be 0 in IDLE.
REQ-013 EXEC (one cycle): jump flag SHALL be set to br_taken if PCJEN & IMM_TYPE==3'b011, to 1 if PCJEN & IMM_TYPE!=3'b011, else 0.
REQ-014 EXEC: MWEN!=0 and MREN!=0 together SHALL pulse illegal next cycle and return to IDLE without retire; exactly one nonzero SHALL go to MEM; neither SHALL go to WB.
REQ-015 MEM: mem_req SHALL be held high with mem_we=(MWEN!=0) and mem_size=the nonzero field until the cycle mem_ack=1, then go to WB.
REQ-016 mem_ack outside MEM SHALL be ignored; mem_ack in the first MEM cycle SHALL be accepted (min 1 MEM cycle).
REQ-017 WB (one cycle): reg_wen=REGEN, wb_sel_mem=(MREN!=0), pc_wen=1, pc_sel_jump=jump flag, retire=1; next state IDLE.
REQ-018 Latency: command accepted at cycle T -> non-memory retire at T+2, in_ready at T+3; memory retire one cycle after the acked MEM cycle.
REQ-019 An all-zero command with hit=1 SHALL retire normally with reg_wen=0 and pc_wen=1, pc_sel_jump=0.

Reset
REQ-020 rst SHALL immediately force IDLE regardless of clk, clear latched command and jump flag.
REQ-021 During/after reset: in_ready=1; every other output 0; reset mid-MEM SHALL drop mem_req at once with no retire.

Configuration
REQ-022 Macro MICRO_SEQ_TIMEOUT_EN defined: a 5-bit counter SHALL count MEM cycles; after 16 consecutive MEM cycles without mem_ack, mem_err SHALL pulse one cycle, mem_req drops, FSM returns to IDLE with no retire.
REQ-023 MICRO_SEQ_TIMEOUT_EN undefined: no counter; MEM waits indefinitely; mem_err SHALL be tied 0.

Verification
REQ-024 micro_cmd=14'h2001 (ADDI), hit=1 at T -> EXEC T+1, WB T+2 with reg_wen=1, pc_wen=1, pc_sel_jump=0, retire=1; in_ready=1 at T+3.
REQ-025 micro_cmd=14'h2181 (LW), mem_ack after 3 MEM cycles -> mem_req=1, mem_we=0, mem_size=11 for 3 cycles; next cycle reg_wen=1, wb_sel_mem=1, retire=1.
REQ-026 micro_cmd=14'h1803 (BEQ): br_taken=1 -> WB pc_sel_jump=1, reg_wen=0; br_taken=0 -> pc_sel_jump=0; 14'h3807 (JAL) -> pc_sel_jump=1 regardless of br_taken.
REQ-027 in_valid=1, hit=0 -> illegal=1 for one cycle, no state change; micro_cmd=14'h0781 (both MWEN/MREN) -> illegal after EXEC, no mem_req.
REQ-028 micro_cmd=14'h0602 (SW), mem_ack=0 forever -> with MICRO_SEQ_TIMEOUT_EN mem_err pulses after 16 MEM cycles and in_ready returns; without it mem_req stays 1; rst mid-MEM -> mem_req=0 same cycle.
